// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Brings up an iCE40 PLL from the board reference clock: pulses RESETB, waits
// for LOCK, qualifies it as stable, then releases the downstream system reset.
// Supervises lock while running and relocks on loss, with bounded retries and
// a sticky fault.
//
// Optional feature macro: PLL_SEQ_DYNDELAY_EN
//   When defined, a 4-phase cfg_req/cfg_ack handshake loads a new DYNAMICDELAY
//   value and forces a full relock around the change. When undefined the
//   handshake is inert: cfg_ack=0 and pll_dyndelay=0.

module pll_lock_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    input  logic       cfg_req,
    input  logic [7:0] cfg_delay,
    output logic       pll_resetb,
    output logic [7:0] pll_dyndelay,
    output logic       sys_reset,
    output logic       locked,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic       cfg_ack
);

    // The single shared counter must reach (largest duration - 1).
    localparam int CNT_MAX_P =
        (RESET_CYCLES > LOCK_TIMEOUT)
            ? ((RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES)
            : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int CNT_W = (CNT_MAX_P > 1) ? $clog2(CNT_MAX_P) : 1;

    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] counter_reg;
    logic             clear_cnt;
    logic [3:0]       retry_reg;
    logic [3:0]       retry_next;
    logic             attempt_failed;

    logic             lock_meta_reg;
    logic             lock_s_reg;

    logic             pll_resetb_reg;
    logic             sys_reset_reg;
    logic             locked_reg;
    logic             fault_reg;

    // cfg_take: a config request may be accepted this cycle (RUN only).
    // cfg_accept: the FSM actually took it (nothing of higher priority won).
    logic             cfg_take;
    logic             cfg_accept;

    // Two-flop synchroniser for the asynchronous PLL LOCK output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= pll_lock;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    // Next-state, retry accounting and config acceptance; restart wins over
    // everything inside the FSM, lock loss wins over a config request.
    always_comb begin
        state_next     = state_reg;
        retry_next     = retry_reg;
        clear_cnt      = 1'b0;
        cfg_accept     = 1'b0;
        attempt_failed = 1'b0;

        if (restart) begin
            state_next = S_RESET;
            retry_next = 4'd0;
            clear_cnt  = 1'b1;
        end else begin
            case (state_reg)
                S_RESET: begin
                    if (counter_reg == RESET_LAST) begin
                        state_next = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s_reg) begin
                        state_next = S_STABLE;
                    end else if (counter_reg == TIMEOUT_LAST) begin
                        attempt_failed = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s_reg) begin
                        attempt_failed = 1'b1;
                    end else if (counter_reg == STABLE_LAST) begin
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!lock_s_reg) begin
                        state_next = S_RESET;
                        retry_next = 4'd0;
                    end else if (cfg_take) begin
                        state_next = S_RESET;
                        retry_next = 4'd0;
                        cfg_accept = 1'b1;
                    end
                end
                S_FAULT: begin
                    state_next = S_FAULT;
                end
                default: begin
                    state_next = S_RESET;
                end
            endcase

            // A failed attempt either retries from S_RESET or gives up.
            if (attempt_failed) begin
                if (retry_reg >= RETRY_LIMIT) begin
                    state_next = S_FAULT;
                end else begin
                    state_next = S_RESET;
                    retry_next = (retry_reg != 4'hF) ? retry_reg + 4'd1 : retry_reg;
                end
            end
        end

        if (state_next != state_reg) begin
            clear_cnt = 1'b1;
        end
    end

    // State and retry registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_RESET;
            retry_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            retry_reg <= retry_next;
        end
    end

    // Shared duration counter: cleared on every state change, saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_reg <= '0;
        end else if (clear_cnt) begin
            counter_reg <= '0;
        end else if (counter_reg != CNT_SAT) begin
            counter_reg <= counter_reg + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself (lock loss shows on sys_reset 3 edges after
    // pll_lock falls: two sync flops plus the transition edge).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pll_resetb_reg <= 1'b0;
            sys_reset_reg  <= 1'b1;
            locked_reg     <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            pll_resetb_reg <= (state_next == S_WAIT_LOCK) ||
                              (state_next == S_STABLE)    ||
                              (state_next == S_RUN);
            sys_reset_reg  <= (state_next != S_RUN);
            locked_reg     <= (state_next == S_RUN);
            fault_reg      <= (state_next == S_FAULT);
        end
    end

    assign pll_resetb  = pll_resetb_reg;
    assign sys_reset   = sys_reset_reg;
    assign locked      = locked_reg;
    assign fault       = fault_reg;
    assign retry_count = retry_reg;

`ifdef PLL_SEQ_DYNDELAY_EN
    logic [7:0] dyndelay_reg;
    logic       cfg_ack_reg;
    // cfg_busy_reg: a request was accepted and its relock has not reached RUN.
    logic       cfg_busy_reg;

    // Only a fresh request (ack low, nothing in flight) is taken, in RUN.
    assign cfg_take = (state_reg == S_RUN) && cfg_req && !cfg_ack_reg && !cfg_busy_reg;

    // Delay register and 4-phase handshake; fault or restart cancels an
    // in-flight request so it is re-taken from RUN while cfg_req stays high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dyndelay_reg <= 8'd0;
            cfg_ack_reg  <= 1'b0;
            cfg_busy_reg <= 1'b0;
        end else if (restart || (state_next == S_FAULT)) begin
            cfg_ack_reg  <= 1'b0;
            cfg_busy_reg <= 1'b0;
        end else if (cfg_accept) begin
            dyndelay_reg <= cfg_delay;
            cfg_busy_reg <= 1'b1;
        end else if (cfg_busy_reg && (state_next == S_RUN) && (state_reg != S_RUN)) begin
            cfg_ack_reg  <= 1'b1;
            cfg_busy_reg <= 1'b0;
        end else if (cfg_ack_reg && !cfg_req) begin
            cfg_ack_reg  <= 1'b0;
        end
    end

    assign pll_dyndelay = dyndelay_reg;
    assign cfg_ack      = cfg_ack_reg;
`else
    // Feature disabled: handshake inputs are deliberately ignored.
    logic cfg_unused;

    assign cfg_take     = 1'b0;
    assign cfg_unused   = ^{cfg_req, cfg_delay, cfg_accept};
    assign pll_dyndelay = 8'd0;
    assign cfg_ack      = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
// Self-checking bench for pll_lock_sequencer with short timing parameters.
// Expected outputs are computed from the sequencing rules with cycle
// arithmetic (attempt period, sync latency, qualification length).

module tb_pll_lock_sequencer;

    localparam int RC = 4;   // RESET_CYCLES
    localparam int LT = 16;  // LOCK_TIMEOUT
    localparam int SC = 8;   // STABLE_CYCLES
    localparam int MR = 2;   // MAX_RETRIES

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       restart;
    logic       cfg_req;
    logic [7:0] cfg_delay;
    logic       pll_resetb;
    logic [7:0] pll_dyndelay;
    logic       sys_reset;
    logic       locked;
    logic       fault;
    logic [3:0] retry_count;
    logic       cfg_ack;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_dly      = 8'h00;

    logic [16:0] obs;
    assign obs = {pll_resetb, sys_reset, locked, fault, retry_count, cfg_ack, pll_dyndelay};

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .restart     (restart),
        .cfg_req     (cfg_req),
        .cfg_delay   (cfg_delay),
        .pll_resetb  (pll_resetb),
        .pll_dyndelay(pll_dyndelay),
        .sys_reset   (sys_reset),
        .locked      (locked),
        .fault       (fault),
        .retry_count (retry_count),
        .cfg_ack     (cfg_ack)
    );

    function automatic logic [16:0] pack(input logic rb, input logic sr, input logic lk,
                                         input logic ft, input logic [3:0] rc,
                                         input logic ak, input logic [7:0] dl);
        return {rb, sr, lk, ft, rc, ak, dl};
    endfunction

    function automatic string fmt(input logic [16:0] v);
        return $sformatf("resetb=%b sys_reset=%b locked=%b fault=%b retry=%0d ack=%b dly=%h",
                         v[16], v[15], v[14], v[13], v[12:9], v[8], v[7:0]);
    endfunction

    // Restart pulse with the PLL reporting no lock; returns just after the restart edge.
    task automatic do_restart();
        restart  = 1'b1;
        pll_lock = 1'b0;
        @(negedge clk);
        restart  = 1'b0;
    endtask

    // From the edge that entered S_RESET: resetb low RC cycles, lock raised k
    // cycles into WAIT_LOCK, RUN on the (SC+3)th edge counting the sampling edge.
    task automatic lock_sequence(input string name, input int k, input logic [3:0] rc_exp);
        logic [16:0] e;
        for (int i = 1; i <= RC + k; i++) begin
            @(negedge clk);
            e = pack(i >= RC, 1'b1, 1'b0, 1'b0, rc_exp, 1'b0, exp_dly);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL %s pre-lock cycle %0d: got %s want %s", name, i, fmt(obs), fmt(e));
                return;
            end
        end
        pll_lock = 1'b1;
        for (int i = 1; i <= SC + 3; i++) begin
            @(negedge clk);
            e = pack(1'b1, i != SC + 3, i == SC + 3, 1'b0, rc_exp, 1'b0, exp_dly);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL %s lock edge %0d: got %s want %s", name, i, fmt(obs), fmt(e));
                return;
            end
        end
        $display("[TB] %s: lock raised %0d cycles into WAIT_LOCK, RUN reached", name, k);
    endtask

    task automatic test_reset();
        logic [16:0] e;
        reset     = 1'b1;
        pll_lock  = 1'b0;
        restart   = 1'b0;
        cfg_req   = 1'b0;
        cfg_delay = 8'h00;
        repeat (3) @(negedge clk);
        e = pack(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL reset_values: got %s want %s", fmt(obs), fmt(e));
        end
        reset = 1'b0;
        $display("[TB] reset: outputs at reset values");
    endtask

    task automatic test_powerup();
        lock_sequence("powerup", 5, 4'd0);
    endtask

    task automatic test_random_relock();
        for (int n = 0; n < 4; n++) begin
            do_restart();
            lock_sequence($sformatf("relock%0d", n), int'($urandom_range(LT - 3, 0)), 4'd0);
        end
    endtask

    // One-cycle lock dropout during qualification: failed attempt, then relock.
    task automatic test_glitch();
        logic [16:0] e;
        int k, j;
        k = int'($urandom_range(LT - 3, 0));
        j = int'($urandom_range(SC - 1, 0));
        do_restart();
        repeat (RC + k) @(negedge clk);
        pll_lock = 1'b1;
        repeat (j + 1) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        @(negedge clk);
        e = pack(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL glitch_before_detect j=%0d: got %s want %s", j, fmt(obs), fmt(e));
        end
        @(negedge clk);
        e = pack(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL glitch_detect j=%0d: got %s want %s", j, fmt(obs), fmt(e));
        end
        repeat (RC + SC) @(negedge clk);
        e = pack(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL glitch_requalify: got %s want %s", fmt(obs), fmt(e));
        end
        @(negedge clk);
        e = pack(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL glitch_run: got %s want %s", fmt(obs), fmt(e));
        end
        $display("[TB] glitch: dropout %0d cycles into STABLE handled", j);
    endtask

    // Two-cycle lock loss in RUN: reset 3 edges later, retry count cleared, relock.
    task automatic test_lock_loss();
        logic [16:0] e;
        pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pll_lock = 1'b1;
        e = pack(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL loss_edge2: got %s want %s", fmt(obs), fmt(e));
        end
        @(negedge clk);
        e = pack(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL loss_edge3: got %s want %s", fmt(obs), fmt(e));
        end
        for (int i = 1; i <= RC + 1 + SC; i++) begin
            @(negedge clk);
            e = pack(i >= RC, i != RC + 1 + SC, i == RC + 1 + SC, 1'b0, 4'd0, 1'b0, exp_dly);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL loss_relock cycle %0d: got %s want %s", i, fmt(obs), fmt(e));
                break;
            end
        end
        $display("[TB] lock_loss: relocked");
    endtask

    // Lock never arrives: MR+1 attempts of RC low / LT high, then sticky fault.
    task automatic test_stuck_lock();
        logic [16:0] e;
        int period, total, attempt, phase;
        period = RC + LT;
        total  = (MR + 1) * period + 6;
        do_restart();
        for (int t = 1; t <= total; t++) begin
            @(negedge clk);
            attempt = t / period;
            phase   = t % period;
            if (attempt > MR) e = pack(1'b0, 1'b1, 1'b0, 1'b1, 4'(MR), 1'b0, exp_dly);
            else              e = pack(phase >= RC, 1'b1, 1'b0, 1'b0, 4'(attempt), 1'b0, exp_dly);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL stuck cycle %0d: got %s want %s", t, fmt(obs), fmt(e));
                break;
            end
        end
        $display("[TB] stuck_lock: fault after %0d attempts", MR + 1);
    endtask

    task automatic test_restart_fault();
        logic [16:0] e;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        e = pack(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL restart_clears_fault: got %s want %s", fmt(obs), fmt(e));
        end
        lock_sequence("after_fault", int'($urandom_range(LT - 3, 0)), 4'd0);
    endtask

`ifdef PLL_SEQ_DYNDELAY_EN
    task automatic test_cfg();
        logic [16:0] e;
        logic [7:0]  d2;
        // First request: A5, full relock, ack until cfg_req drops.
        cfg_delay = 8'hA5;
        cfg_req   = 1'b1;
        @(negedge clk);
        exp_dly = 8'hA5;
        e = pack(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL cfg_accept: got %s want %s", fmt(obs), fmt(e));
        end
        for (int i = 1; i <= RC + 1 + SC + 2; i++) begin
            @(negedge clk);
            e = pack(i >= RC, i < RC + 1 + SC, i >= RC + 1 + SC, 1'b0, 4'd0,
                     i >= RC + 1 + SC, exp_dly);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL cfg_relock cycle %0d: got %s want %s", i, fmt(obs), fmt(e));
                break;
            end
        end
        cfg_req = 1'b0;
        @(negedge clk);
        e = pack(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL cfg_ack_fall: got %s want %s", fmt(obs), fmt(e));
        end
        $display("[TB] cfg: delay A5 loaded and acknowledged");

        // Second request cancelled by restart mid-relock, then re-accepted.
        d2        = 8'($urandom_range(255, 0));
        cfg_delay = d2;
        cfg_req   = 1'b1;
        @(negedge clk);
        exp_dly = d2;
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        e = pack(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL cfg_restart: got %s want %s", fmt(obs), fmt(e));
        end
        for (int i = 1; i <= RC + 1 + SC; i++) begin
            @(negedge clk);
            e = pack(i >= RC, i != RC + 1 + SC, i == RC + 1 + SC, 1'b0, 4'd0, 1'b0, exp_dly);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL cfg_cancel_relock cycle %0d: got %s want %s", i, fmt(obs), fmt(e));
                break;
            end
        end
        @(negedge clk);
        e = pack(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL cfg_reaccept: got %s want %s", fmt(obs), fmt(e));
        end
        for (int i = 1; i <= RC + 1 + SC; i++) begin
            @(negedge clk);
            e = pack(i >= RC, i != RC + 1 + SC, i == RC + 1 + SC, 1'b0, 4'd0,
                     i == RC + 1 + SC, exp_dly);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL cfg_reaccept_relock cycle %0d: got %s want %s", i, fmt(obs), fmt(e));
                break;
            end
        end
        cfg_req = 1'b0;
        @(negedge clk);
        e = pack(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL cfg_ack_fall2: got %s want %s", fmt(obs), fmt(e));
        end
        $display("[TB] cfg: delay %h re-accepted after restart", d2);
    endtask
`else
    task automatic test_cfg();
        logic [16:0] e;
        cfg_delay = 8'($urandom_range(255, 1));
        cfg_req   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            e = pack(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL cfg_ignored cycle %0d: got %s want %s", i, fmt(obs), fmt(e));
                break;
            end
        end
        cfg_req = 1'b0;
        $display("[TB] cfg: request ignored with feature disabled");
    endtask
`endif

    // Reset asserted between edges while waiting for lock on the second attempt.
    task automatic test_async_reset();
        logic [16:0] e;
        do_restart();
        repeat (RC + LT + RC + 3) @(negedge clk);
        e = pack(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, exp_dly);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL async_pre: got %s want %s", fmt(obs), fmt(e));
        end
        #2;
        reset = 1'b1;
        #1;
        exp_dly = 8'h00;
        e = pack(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL async_reset: got %s want %s", fmt(obs), fmt(e));
        end
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] async_reset: outputs cleared without a clock edge");
        lock_sequence("after_reset", int'($urandom_range(LT - 3, 0)), 4'd0);
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_random_relock();
        test_glitch();
        test_lock_loss();
        test_stuck_lock();
        test_restart_fault();
        test_cfg();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
